// File: rtl/cpu_regfile_p.sv
// Parameterized register file: multi-port combinational read with same-cycle write bypass.
// After reset, a clear sweep zeroes every register. Writes that arrive during the sweep are dropped and flagged.
module cpu_regfile_p #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic [ADDR_W-1:0]   w_clr_idx_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_wr_drop;
  logic                w_wr_drop_nxt;

  logic [DATA_W-1:0]   r_regs [NREG];

  logic                w_r0_discard;
  logic                w_user_wr;
  logic                w_sweep_wr;

  // A write to R0 is silently absorbed when R0 is hard-wired; it is not a drop.
  assign w_r0_discard = (ZERO_R0 != 0) && (wa == '0);
  assign w_user_wr    = RST_N && (r_state == S_READY) && we && !w_r0_discard;
  assign w_sweep_wr   = RST_N && (r_state == S_CLEAR);

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_wr_drop_nxt = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
        w_wr_drop_nxt = we;
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        w_state_nxt = S_READY;
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_idx_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_CLEAR);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  // Storage carries no reset; the sweep is what defines its contents.
  always_ff @(posedge CLK) begin
    if (w_sweep_wr) begin
      r_regs[r_clr_idx] <= '0;
    end else if (w_user_wr) begin
      r_regs[wa] <= wd;
    end
  end

  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_val;

    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Later overrides win: bypass beats storage, R0 and sweep beat everything.
    always_comb begin
      w_val = r_regs[w_ra];
      if (w_user_wr && (wa == w_ra)) begin
        w_val = wd;
      end
      if ((ZERO_R0 != 0) && (w_ra == '0)) begin
        w_val = '0;
      end
      if (r_state == S_CLEAR) begin
        w_val = '0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_val;
  end

endmodule

// File: tb/tb_cpu_regfile_p.sv
// Randomized and directed bench for cpu_regfile_p against an array-based reference model.
module tb_cpu_regfile_p;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NREG = 32;

  logic              CLK;
  logic              RST_N;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DW-1:0]     wd;
  logic              busy;
  logic              wr_drop;

  logic [AW-1:0]     ra [NRD];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mem [NREG];
  int            sweep_left;
  logic          exp_busy;
  logic          exp_drop;

  assign rd_addr = {ra[1], ra[0]};

  cpu_regfile_p #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_R0(1)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (sweep_left > 0)                        return '0;
    if (a == 0)                                return '0;
    if (RST_N && we && wa != 0 && wa == a)     return wd;
    return mem[a];
  endfunction

  // Model behaviour at a rising edge, using the inputs currently applied.
  task automatic model_edge();
    if (!RST_N) begin
      sweep_left = NREG;
      exp_drop   = 1'b0;
    end else if (sweep_left > 0) begin
      exp_drop   = we;
      sweep_left = sweep_left - 1;
      if (sweep_left == 0) begin
        for (int i = 0; i < NREG; i++) mem[i] = '0;
      end
    end else begin
      exp_drop = 1'b0;
      if (we && wa != 0) mem[wa] = wd;
    end
    exp_busy = (sweep_left > 0);
  endtask

  // Check all outputs mid-cycle, then advance one clock; returns at the next falling edge.
  task automatic step();
    #1;
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("rd%0d[%0d]", k, ra[k]), 64'(rd_data[k*DW +: DW]), 64'(model_read(ra[k])));
    end
    check("busy", 64'(busy), 64'(exp_busy));
    check("wr_drop", 64'(wr_drop), 64'(exp_drop));
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
  endtask

  // Counts cycles with busy high after reset release; bounded.
  task automatic count_sweep(input string tag);
    int cnt;
    cnt = 0;
    for (int g = 0; g < 100; g++) begin
      if (!busy) break;
      cnt++;
      step();
    end
    check(tag, 64'(cnt), 64'(NREG));
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    ra[0] = '0; ra[1] = '0;
    sweep_left = NREG;
    exp_busy = 1'b1;
    exp_drop = 1'b0;
    for (int i = 0; i < NREG; i++) mem[i] = 'x;

    // First edge establishes reset state before anything is compared.
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    step();

    // Reset release and sweep length
    RST_N = 1'b1;
    count_sweep("sweep_len_release");
    for (int i = 0; i < NREG; i++) begin
      ra[0] = AW'(i); ra[1] = AW'(NREG - 1 - i);
      #1;
      check("clear_rd0", 64'(rd_data[0 +: DW]), 64'd0);
      step();
    end

    // Write then read on both ports
    we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
    step();
    idle();
    ra[0] = 5'd7; ra[1] = 5'd7;
    #1;
    check("wr7_p0", 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
    check("wr7_p1", 64'(rd_data[DW +: DW]), 64'hDEADBEEF);
    step();

    // Same-cycle bypass
    we = 1'b1; wa = 5'd9; wd = 32'h12345678; ra[1] = 5'd9; ra[0] = 5'd7;
    #1;
    check("bypass_p1", 64'(rd_data[DW +: DW]), 64'h12345678);
    step();
    idle();

    // R0 stays zero, no drop pulse
    we = 1'b1; wa = '0; wd = 32'hFFFFFFFF; ra[0] = '0; ra[1] = '0;
    #1;
    check("r0_same", 64'(rd_data[0 +: DW]), 64'd0);
    step();
    idle();
    #1;
    check("r0_next", 64'(rd_data[DW +: DW]), 64'd0);
    check("r0_nodrop", 64'(wr_drop), 64'd0);
    step();

    // Write dropped during sweep
    we = 1'b1; wa = 5'd3; wd = 32'h55;
    step();
    idle();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) step();
    we = 1'b1; wa = 5'd3; wd = 32'hAA;
    step();
    idle();
    #1;
    check("drop_pulse", 64'(wr_drop), 64'd1);
    step();
    check("drop_once", 64'(wr_drop), 64'd0);
    for (int g = 0; g < 100 && busy; g++) step();
    ra[0] = 5'd3; ra[1] = 5'd3;
    #1;
    check("drop_r3", 64'(rd_data[0 +: DW]), 64'd0);
    step();

    // Reset in the middle of a sweep restarts it
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) step();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    count_sweep("sweep_len_restart");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      RST_N = ($urandom_range(0, 299) != 0);
      we = $urandom_range(0, 1);
      wa = AW'($urandom_range(0, NREG - 1));
      wd = $urandom;
      for (int k = 0; k < NRD; k++) begin
        ra[k] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_regfile_p.md
CPU_REGFILE_P -- requirements
Module: cpu_regfile_p

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5: address width; depth NREG = 2**ADDR_W.
REQ-003 The block SHALL have parameter NRD, default 2: number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_R0, default 1: when 1, register 0 reads 0 and ignores writes.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RST_N, input, 1: synchronous, active-low reset.
REQ-007 The block SHALL have port rd_addr, input, NRD*ADDR_W: read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port rd_data, output, NRD*DATA_W: read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have port we, input, 1: write enable.
REQ-010 The block SHALL have port wa, input, ADDR_W: write address.
REQ-011 The block SHALL have port wd, input, DATA_W: write data.
REQ-012 The block SHALL have port busy, output, 1: high while the register-clear sweep is in progress.
REQ-013 The block SHALL have port wr_drop, output, 1: one-cycle pulse when a write is discarded.

Function
REQ-014 The block SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 In CLEAR, a counter clr_idx SHALL write 0 to register[clr_idx] each cycle, then increment by 1.
REQ-016 When clr_idx = NREG-1 is written, the FSM SHALL move to READY on the same edge; the sweep therefore lasts exactly NREG cycles.
REQ-017 busy SHALL be 1 in CLEAR and 0 in READY; it is a registered output.
REQ-018 In CLEAR, every rd_data port SHALL return 0, regardless of address.
REQ-019 In CLEAR, we=1 SHALL NOT modify any register; wr_drop SHALL be 1 in the following cycle, otherwise 0.
REQ-020 In READY, we=1 SHALL write wd to register[wa] at the rising edge; write latency is 1 cycle.
REQ-021 In READY with ZERO_R0=1 and wa=0, the write SHALL be discarded and SHALL NOT pulse wr_drop.
REQ-022 Reads SHALL be combinational: rd_data[k] reflects register[rd_addr[k]] in the same cycle.
REQ-023 Write-to-read bypass: in READY, when we=1 and rd_addr[k]=wa (and wa is not a discarded R0 write), rd_data[k] SHALL equal wd in that same cycle.
REQ-024 With ZERO_R0=1, rd_addr[k]=0 SHALL always read 0, bypass included.
REQ-025 All NRD ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-026 Register contents SHALL persist indefinitely in READY with we=0.

Reset
REQ-027 RST_N=0 sampled at a rising edge SHALL set the FSM to CLEAR, clr_idx to 0, busy to 1 and wr_drop to 0.
REQ-028 While RST_N=0, the FSM SHALL hold CLEAR with clr_idx=0; the sweep begins on the first edge with RST_N=1.
REQ-029 Reset asserted mid-sweep or in READY SHALL restart the full sweep from index 0; partial contents are not guaranteed until busy falls.
REQ-030 RST_N=0 SHALL take priority over we on the same edge.

Verification
REQ-031 Reset release, defaults: RST_N low for 2 cycles, then high -> busy=1 for exactly 32 cycles, then 0; all 32 registers read 0.
REQ-032 Write/read: in READY, write 0xDEADBEEF to register 7 -> next cycle rd_addr port0=7 gives 0xDEADBEEF; port1=7 gives the same.
REQ-033 Bypass: in READY, we=1, wa=9, wd=0x12345678, port1 addr=9 in the same cycle -> rd_data port1=0x12345678 before the edge.
REQ-034 R0 rule: write 0xFFFFFFFF to wa=0 -> R0 reads 0 in the same and next cycles; wr_drop stays 0.
REQ-035 Drop during sweep: we=1, wa=3, wd=0xAA at sweep cycle 5 -> wr_drop=1 next cycle; after READY, register 3 reads 0.
REQ-036 Mid-sweep reset: RST_N low 1 cycle at sweep cycle 20 -> busy stays 1 for 32 further cycles after release; all reads return 0 afterward.
